alu_pipe_param: RTL
===================

ALU_PIPE_PARAM -- requirements
Module: alu_pipe_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand/result width in bits; legal range 4..64.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid  input  1  operand/opcode valid.
REQ-005 The block SHALL have port in_ready  output  1  block can accept an operation.
REQ-006 The block SHALL have port A  input  WIDTH  operand A.
REQ-007 The block SHALL have port B  input  WIDTH  operand B, or shift amount for variable-shift ops.
REQ-008 The block SHALL have port sel  input  4  opcode.
REQ-009 The block SHALL have port out_valid  output  1  result/flags valid.
REQ-010 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 The block SHALL have port R  output  WIDTH  result.
REQ-012 The block SHALL have ports C, Z, V, N  output  1 each  carry/borrow, zero, signed overflow, negative flags.

Function
REQ-013 The block SHALL accept an operation only on a rising edge with in_valid=1 and in_ready=1, capturing A, B, sel; later input changes SHALL have no effect on that operation.
REQ-014 in_ready SHALL be 1 iff FSM is IDLE and (out_valid=0 or out_ready=1), allowing back-to-back accept in the same cycle a result is taken.
REQ-015 FSM states SHALL be IDLE and SHIFT: IDLE->SHIFT on acceptance of opcodes 1010-1101 with effective amount k>0; SHIFT->IDLE when the cycle counter reaches k, loading the output register; all other ops stay IDLE.
REQ-016 Single-cycle ops SHALL assert out_valid on the edge after acceptance (latency 1); variable shifts SHALL assert it k+1 edges after acceptance (k=0 gives latency 1).
REQ-017 Opcodes SHALL be: 0000 ADD A+B; 0001 SUB A-B; 0010 AND; 0011 OR; 0100 XOR; 0101 NOT A; 0110 SHL A by 1; 0111 SHR A by 1 (logical); 1000 ADC A+B+CF; 1001 SBB A-B-CF; 1010 SHL A by k; 1011 SHR A by k (logical); 1100 ASR A by k; 1101 ROL A by k; 1110/1111 reserved.
REQ-018 ADD/ADC: C SHALL be bit WIDTH of the WIDTH+1-bit sum; V=1 iff the operand signs are equal and R sign differs.
REQ-019 SUB/SBB: C SHALL be 1 on borrow (unsigned A < B+cin); V=1 iff the operand signs differ and R sign differs from A.
REQ-020 For SHL/SHR/ASR, k SHALL be min(B, WIDTH), with k=WIDTH giving 0 (SHL/SHR) or all copies of A[WIDTH-1] (ASR); for ROL, k SHALL be B mod WIDTH.
REQ-021 Shifts SHALL set C to the last bit shifted out (0 when k=0; ROL: the new R[0]); V SHALL be 0 for all non-add/sub ops, and C SHALL be 0 for logic ops.
REQ-022 Z SHALL be (R==0) and N SHALL be R[WIDTH-1] for every op.
REQ-023 Reserved opcodes SHALL produce R=0, C=0, V=0, N=0, Z=1 with latency 1.
REQ-024 Internal carry register CF SHALL load C whenever a result is loaded into the output register; ADC/SBB SHALL use CF as it stands at acceptance.
REQ-025 While out_valid=1 and out_ready=0, R, C, Z, V, N SHALL hold stable; out_valid SHALL drop on the edge where out_ready=1 and no new result loads.

Reset
REQ-026 On an edge with rst_n=0 the block SHALL enter IDLE, clear the shift counter and CF, and drive out_valid=0, R=0, C=0, Z=0, V=0, N=0; in_ready SHALL read 1 once rst_n=1.
REQ-027 Reset asserted during SHIFT SHALL abort the operation with no result produced.

Verification (WIDTH=8)
REQ-028 ADD A=0x7F B=0x01 -> one cycle later out_valid=1, R=0x80, C=0, V=1, N=1, Z=0.
REQ-029 SUB 0x00-0x01 -> R=0xFF, C=1, N=1; then ADC 0x00+0x00 -> R=0x01, C=0, Z=0.
REQ-030 SHL-by-k A=0x81 B=3 -> in_ready=0 for 3 cycles, out_valid at accept+4, R=0x08, C=0.
REQ-031 ASR A=0x80 B=9 -> k=8, out_valid at accept+9, R=0xFF, C=1, N=1; ROL A=0x81 B=9 -> R=0x03, C=1, latency 2.
REQ-032 out_ready=0 for 5 cycles after a result -> R/flags stable, in_ready=0; then out_ready=1 with in_valid=1 -> new op accepted that same edge, next result one cycle later.
REQ-033 rst_n=0 for one edge mid-SHIFT -> out_valid=0, all outputs 0, CF=0; subsequent ADC 0x01+0x01 -> R=0x02.

Source files
------------

// File: rtl/alu_pipe_param.sv
// Registered ALU with handshake in/out; variable shifts stall the input for k
// cycles while a counter walks up to the shift amount before the result loads.
//
// state | meaning
// IDLE  | accepting ops; single-cycle results load on the accept edge
// SHIFT | variable shift in flight; result loads when cnt reaches k
module alu_pipe_param #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R,
  output logic             C,
  output logic             Z,
  output logic             V,
  output logic             N
);

  localparam int KW = $clog2(WIDTH + 1);
  localparam logic [0:0] STATE_IDLE  = 1'b0;
  localparam logic [0:0] STATE_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [KW-1:0]    cnt_q, cnt_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] pend_r_q, pend_r_d;
  logic             pend_c_q, pend_c_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             c_q, c_d, z_q, z_d, v_q, v_d, n_q, n_d;
  logic             out_valid_q, out_valid_d;
  logic             cf_q, cf_d;

  logic [KW-1:0]         k_lin, k_rol, k_eff;
  logic                  cin, var_shift;
  logic [WIDTH:0]        add_w, sub_w, shl_w, shr_w;
  logic signed [WIDTH:0] asr_w;
  logic [WIDTH-1:0]      rol_r;
  logic [WIDTH-1:0]      alu_r;
  logic                  alu_c, alu_v;

  always_comb begin
    k_lin = (B >= WIDTH'(WIDTH)) ? KW'(WIDTH) : B[KW-1:0];
    k_rol = KW'(B % WIDTH'(WIDTH));
    // Carry-in only applies to ADC/SBB, which are the sel[3] variants of ADD/SUB.
    cin   = sel[3] & cf_q;
    add_w = {1'b0, A} + {1'b0, B} + (WIDTH+1)'(cin);
    sub_w = {1'b0, A} - {1'b0, B} - (WIDTH+1)'(cin);
    shl_w = {1'b0, A} << k_lin;
    shr_w = {A, 1'b0} >> k_lin;
    asr_w = $signed({A, 1'b0}) >>> k_lin;
    rol_r = (A << k_rol) | (A >> (KW'(WIDTH) - k_rol));
    var_shift = (sel >= 4'b1010) && (sel <= 4'b1101);
    k_eff = k_lin;
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (sel)
      4'b0000, 4'b1000: begin
        alu_r = add_w[WIDTH-1:0];
        alu_c = add_w[WIDTH];
        alu_v = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0001, 4'b1001: begin
        alu_r = sub_w[WIDTH-1:0];
        alu_c = sub_w[WIDTH];
        alu_v = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0010: alu_r = A & B;
      4'b0011: alu_r = A | B;
      4'b0100: alu_r = A ^ B;
      4'b0101: alu_r = ~A;
      4'b0110: begin
        alu_r = {A[WIDTH-2:0], 1'b0};
        alu_c = A[WIDTH-1];
      end
      4'b0111: begin
        alu_r = {1'b0, A[WIDTH-1:1]};
        alu_c = A[0];
      end
      4'b1010: begin
        alu_r = shl_w[WIDTH-1:0];
        alu_c = shl_w[WIDTH];
      end
      4'b1011: begin
        alu_r = shr_w[WIDTH:1];
        alu_c = shr_w[0];
      end
      4'b1100: begin
        alu_r = asr_w[WIDTH:1];
        alu_c = asr_w[0];
      end
      4'b1101: begin
        k_eff = k_rol;
        alu_r = rol_r;
        alu_c = (k_rol != '0) & rol_r[0];
      end
      default: ;
    endcase
  end

  logic             accept, load;
  logic [WIDTH-1:0] ld_r;
  logic             ld_c, ld_v;

  always_comb begin
    in_ready    = (state_q == STATE_IDLE) && (!out_valid_q || out_ready);
    accept      = in_valid && in_ready;
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    pend_r_d    = pend_r_q;
    pend_c_d    = pend_c_q;
    r_d         = r_q;
    c_d         = c_q;
    z_d         = z_q;
    v_d         = v_q;
    n_d         = n_q;
    out_valid_d = out_valid_q;
    cf_d        = cf_q;
    load        = 1'b0;
    ld_r        = alu_r;
    ld_c        = alu_c;
    ld_v        = alu_v;
    case (state_q)
      STATE_IDLE: begin
        if (accept) begin
          if (var_shift && (k_eff != '0)) begin
            state_d  = STATE_SHIFT;
            cnt_d    = KW'(1);
            k_d      = k_eff;
            pend_r_d = alu_r;
            pend_c_d = alu_c;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: begin
        if (cnt_q == k_q) begin
          state_d = STATE_IDLE;
          load    = 1'b1;
          ld_r    = pend_r_q;
          ld_c    = pend_c_q;
          ld_v    = 1'b0;
        end else begin
          cnt_d = cnt_q + KW'(1);
        end
      end
    endcase
    if (load) begin
      r_d         = ld_r;
      c_d         = ld_c;
      v_d         = ld_v;
      z_d         = (ld_r == '0);
      n_d         = ld_r[WIDTH-1];
      out_valid_d = 1'b1;
      cf_d        = ld_c;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= STATE_IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      pend_r_q    <= '0;
      pend_c_q    <= 1'b0;
      r_q         <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      v_q         <= 1'b0;
      n_q         <= 1'b0;
      out_valid_q <= 1'b0;
      cf_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      pend_r_q    <= pend_r_d;
      pend_c_q    <= pend_c_d;
      r_q         <= r_d;
      c_q         <= c_d;
      z_q         <= z_d;
      v_q         <= v_d;
      n_q         <= n_d;
      out_valid_q <= out_valid_d;
      cf_q        <= cf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign R = r_q;
  assign C = c_q;
  assign Z = z_q;
  assign V = v_q;
  assign N = n_q;

endmodule
